// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: bus widths, bus field offsets, div_op encoding
// and the divider state type.
package pipe_pkg;
    localparam int ID_EXE_W  = 183;
    localparam int EXE_MEM_W = 103;
    localparam int EXE_WR_W  = 39;

    // ID_to_EXE_bus field LSB positions
    localparam int IE_INST_LSB    = 0;
    localparam int IE_PC_LSB      = 32;
    localparam int IE_RKD_LSB     = 64;
    localparam int IE_DEST_LSB    = 96;
    localparam int IE_MEM_WE_BIT  = 101;
    localparam int IE_GR_WE_BIT   = 102;
    localparam int IE_RES_MEM_BIT = 103;
    localparam int IE_DIV_OP_LSB  = 104;
    localparam int IE_SRC2_LSB    = 107;
    localparam int IE_SRC1_LSB    = 139;
    localparam int IE_ALU_OP_LSB  = 171;

    // EXE_to_MEM_bus field LSB positions
    localparam int EM_INST_LSB    = 0;
    localparam int EM_PC_LSB      = 32;
    localparam int EM_DEST_LSB    = 64;
    localparam int EM_GR_WE_BIT   = 69;
    localparam int EM_RES_MEM_BIT = 70;
    localparam int EM_RESULT_LSB  = 71;

    // EXE_wr_bus field LSB positions
    localparam int WR_RESULT_LSB  = 0;
    localparam int WR_DEST_LSB    = 32;
    localparam int WR_IS_LOAD_BIT = 37;
    localparam int WR_WRITE_BIT   = 38;

    // div_op = {is_div, is_signed, want_rem}
    localparam int DIV_OP_IS_DIV = 2;
    localparam int DIV_OP_SIGNED = 1;
    localparam int DIV_OP_REM    = 0;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;
endpackage

// File: rtl/exe_stage_if.sv
// Decode/memory-side handshake and bus signals of the execute stage.
interface exe_stage_if;
    import pipe_pkg::*;

    logic                 ID_to_EXE_valid;
    logic [ID_EXE_W-1:0]  ID_to_EXE_bus;
    logic                 EXE_allow_in;
    logic                 EXE_to_MEM_valid;
    logic                 MEM_allow_in;
    logic [EXE_MEM_W-1:0] EXE_to_MEM_bus;
    logic                 data_sram_en;
    logic [3:0]           data_sram_we;
    logic [31:0]          data_sram_addr;
    logic [31:0]          data_sram_wdata;
    logic [EXE_WR_W-1:0]  EXE_wr_bus;

    modport master (
        output ID_to_EXE_valid, ID_to_EXE_bus, MEM_allow_in,
        input  EXE_allow_in, EXE_to_MEM_valid, EXE_to_MEM_bus,
               data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata, EXE_wr_bus
    );

    modport slave (
        input  ID_to_EXE_valid, ID_to_EXE_bus, MEM_allow_in,
        output EXE_allow_in, EXE_to_MEM_valid, EXE_to_MEM_bus,
               data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata, EXE_wr_bus
    );
endinterface

// File: rtl/alu.sv
// Single-cycle ALU with one-hot operation select:
// add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui.
module alu (
    input  logic [11:0] alu_op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic [31:0] result
);
    logic        use_sub;
    logic [31:0] b_in;
    logic [32:0] sum;
    logic        slt_res;
    logic        sltu_res;

    // sub/slt/sltu share the adder as src1 + ~src2 + 1
    assign use_sub  = alu_op[1] | alu_op[2] | alu_op[3];
    assign b_in     = use_sub ? ~src2 : src2;
    assign sum      = {1'b0, src1} + {1'b0, b_in} + {32'b0, use_sub};
    assign slt_res  = (src1[31] & ~src2[31]) | (~(src1[31] ^ src2[31]) & sum[31]);
    assign sltu_res = ~sum[32];

    always_comb begin
        result = '0;
        if (alu_op[0] | alu_op[1]) result = result | sum[31:0];
        if (alu_op[2])  result = result | {31'b0, slt_res};
        if (alu_op[3])  result = result | {31'b0, sltu_res};
        if (alu_op[4])  result = result | (src1 & src2);
        if (alu_op[5])  result = result | ~(src1 | src2);
        if (alu_op[6])  result = result | (src1 | src2);
        if (alu_op[7])  result = result | (src1 ^ src2);
        if (alu_op[8])  result = result | (src1 << src2[4:0]);
        if (alu_op[9])  result = result | (src1 >> src2[4:0]);
        if (alu_op[10]) result = result | 32'($signed(src1) >>> src2[4:0]);
        if (alu_op[11]) result = result | src2;
    end
endmodule

// File: rtl/div_iter.sv
// Iterative restoring divider: one quotient bit per cycle on magnitudes,
// sign fix-up and divide-by-zero handling applied on the outputs.
module div_iter
    import pipe_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ack,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);
    localparam int CW = $clog2(DIV_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DIV_CYCLES - 1);

    div_state_t  state_reg;
    logic [CW-1:0] count_reg;
    logic [31:0] rem_reg;
    logic [31:0] quo_reg;
    logic [31:0] dvs_reg;
    logic        neg_q_reg;
    logic        neg_r_reg;
    logic        zero_reg;

    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic [32:0] shifted;
    logic [32:0] diff;

    assign a_abs   = (is_signed & dividend[31]) ? -dividend : dividend;
    assign b_abs   = (is_signed & divisor[31])  ? -divisor  : divisor;
    assign shifted = {rem_reg, quo_reg[31]};
    assign diff    = shifted - {1'b0, dvs_reg};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
            rem_reg   <= '0;
            quo_reg   <= '0;
            dvs_reg   <= '0;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
            zero_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: if (start) begin
                    state_reg <= BUSY;
                    count_reg <= '0;
                    rem_reg   <= '0;
                    quo_reg   <= a_abs;
                    dvs_reg   <= b_abs;
                    neg_q_reg <= is_signed & (dividend[31] ^ divisor[31]);
                    neg_r_reg <= is_signed & dividend[31];
                    zero_reg  <= (divisor == 32'd0);
                end
                BUSY: begin
                    // a borrow out of the 33-bit subtract means "restore"
                    rem_reg   <= diff[32] ? shifted[31:0] : diff[31:0];
                    quo_reg   <= {quo_reg[30:0], ~diff[32]};
                    count_reg <= count_reg + 1'b1;
                    if (count_reg == LAST) state_reg <= DONE;
                end
                DONE: if (ack) state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    // With a zero divisor the remainder register already ends up holding |dividend|
    assign done      = (state_reg == DONE);
    assign quotient  = zero_reg ? 32'hFFFF_FFFF : (neg_q_reg ? -quo_reg : quo_reg);
    assign remainder = neg_r_reg ? -rem_reg : rem_reg;
endmodule

// File: rtl/exe_stage.sv
// Execute stage: pipeline handshake, ALU/divider result select, data-SRAM
// request and the forwarding/load-use bus back to decode.
module exe_stage
    import pipe_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    exe_stage_if.slave  io
);
    logic                exe_valid_reg;
    logic [ID_EXE_W-1:0] bus_reg;

    logic [11:0] alu_op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [2:0]  div_op;
    logic        res_from_mem;
    logic        gr_we;
    logic        mem_we;
    logic [4:0]  dest;
    logic [31:0] rkd_value;
    logic [31:0] pc;
    logic [31:0] inst;

    logic [31:0] alu_result;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic [31:0] result;
    logic        is_div;
    logic        div_done;
    logic        ready_go;
    logic        to_mem_valid;
    logic        handoff;

    assign alu_op       = bus_reg[IE_ALU_OP_LSB +: 12];
    assign src1         = bus_reg[IE_SRC1_LSB +: 32];
    assign src2         = bus_reg[IE_SRC2_LSB +: 32];
    assign div_op       = bus_reg[IE_DIV_OP_LSB +: 3];
    assign res_from_mem = bus_reg[IE_RES_MEM_BIT];
    assign gr_we        = bus_reg[IE_GR_WE_BIT];
    assign mem_we       = bus_reg[IE_MEM_WE_BIT];
    assign dest         = bus_reg[IE_DEST_LSB +: 5];
    assign rkd_value    = bus_reg[IE_RKD_LSB +: 32];
    assign pc           = bus_reg[IE_PC_LSB +: 32];
    assign inst         = bus_reg[IE_INST_LSB +: 32];

    assign is_div       = div_op[DIV_OP_IS_DIV];
    assign ready_go     = ~is_div | div_done;
    assign to_mem_valid = exe_valid_reg & ready_go;
    assign handoff      = to_mem_valid & io.MEM_allow_in;

    assign io.EXE_allow_in     = ~exe_valid_reg | handoff;
    assign io.EXE_to_MEM_valid = to_mem_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exe_valid_reg <= 1'b0;
            bus_reg       <= '0;
        end else begin
            if (io.EXE_allow_in) exe_valid_reg <= io.ID_to_EXE_valid;
            if (io.ID_to_EXE_valid & io.EXE_allow_in) bus_reg <= io.ID_to_EXE_bus;
        end
    end

    alu u_alu (
        .alu_op (alu_op),
        .src1   (src1),
        .src2   (src2),
        .result (alu_result)
    );

    div_iter #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (exe_valid_reg & is_div),
        .ack       (handoff),
        .is_signed (div_op[DIV_OP_SIGNED]),
        .dividend  (src1),
        .divisor   (src2),
        .done      (div_done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    assign result = ~is_div ? alu_result : (div_op[DIV_OP_REM] ? remainder : quotient);

    // The request fires only on the cycle the instruction moves into MEM
    assign io.data_sram_en    = exe_valid_reg & (res_from_mem | mem_we) & io.MEM_allow_in & ready_go;
    assign io.data_sram_we    = mem_we ? 4'hF : 4'h0;
    assign io.data_sram_addr  = alu_result;
    assign io.data_sram_wdata = rkd_value;

    always_comb begin
        io.EXE_to_MEM_bus = '0;
        io.EXE_to_MEM_bus[EM_RESULT_LSB +: 32] = result;
        io.EXE_to_MEM_bus[EM_RES_MEM_BIT]      = res_from_mem;
        io.EXE_to_MEM_bus[EM_GR_WE_BIT]        = gr_we;
        io.EXE_to_MEM_bus[EM_DEST_LSB +: 5]    = dest;
        io.EXE_to_MEM_bus[EM_PC_LSB +: 32]     = pc;
        io.EXE_to_MEM_bus[EM_INST_LSB +: 32]   = inst;
    end

    always_comb begin
        io.EXE_wr_bus = '0;
        io.EXE_wr_bus[WR_WRITE_BIT]         = gr_we & exe_valid_reg;
        io.EXE_wr_bus[WR_IS_LOAD_BIT]       = res_from_mem & exe_valid_reg;
        io.EXE_wr_bus[WR_DEST_LSB +: 5]     = dest;
        io.EXE_wr_bus[WR_RESULT_LSB +: 32]  = result;
    end
endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: ALU path, divider timing/results, SRAM
// request timing under backpressure and reset during a division.
module tb_exe_stage;
    import pipe_pkg::*;

    localparam logic [31:0] PC_C   = 32'h1C00_0010;
    localparam logic [31:0] INST_C = 32'h0010_1C83;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    exe_stage_if io ();

    exe_stage #(.DIV_CYCLES(32)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (io.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    function automatic logic [ID_EXE_W-1:0] mk(input logic [11:0] aop, input logic [31:0] s1,
                                               input logic [31:0] s2, input logic [2:0] dop,
                                               input logic rfm, input logic gwe, input logic mwe,
                                               input logic [4:0] dst, input logic [31:0] rkd);
        return {aop, s1, s2, dop, rfm, gwe, mwe, dst, rkd, PC_C, INST_C};
    endfunction

    task automatic issue(input logic [ID_EXE_W-1:0] b);
        io.ID_to_EXE_valid = 1'b1;
        io.ID_to_EXE_bus   = b;
        tick();
        io.ID_to_EXE_valid = 1'b0;
    endtask

    // Waits from cycle 0 until EXE_to_MEM_valid; returns the residency cycle index
    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (io.EXE_to_MEM_valid !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
    endtask

    task automatic run_div(input string tag, input logic sgn, input logic rem,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int cyc;
        issue(mk(12'h000, a, b, {1'b1, sgn, rem}, 1'b0, 1'b1, 1'b0, 5'd7, 32'h0));
        chk({tag, " c0 allow_in"}, 32'(io.EXE_allow_in), 32'd0);
        chk({tag, " c0 write/load"}, 32'(io.EXE_wr_bus[38:37]), 32'd2);
        wait_valid(cyc);
        chk({tag, " latency"}, 32'(cyc), 32'd33);
        chk({tag, " result"}, io.EXE_to_MEM_bus[102:71], exp);
        $display("tx %s a=%08h b=%08h -> %08h after %0d cycles", tag, a, b,
                 io.EXE_to_MEM_bus[102:71], cyc);
        tick();
    endtask

    initial begin
        int cyc;
        io.ID_to_EXE_valid = 1'b0;
        io.ID_to_EXE_bus   = '0;
        io.MEM_allow_in    = 1'b0;
        #1 reset = 1'b1;
        tick();
        tick();
        chk("rst allow_in", 32'(io.EXE_allow_in), 32'd1);
        chk("rst to_mem_valid", 32'(io.EXE_to_MEM_valid), 32'd0);
        chk("rst bus result", io.EXE_to_MEM_bus[102:71], 32'd0);
        chk("rst bus pc", io.EXE_to_MEM_bus[63:32], 32'd0);
        chk("rst sram_en", 32'(io.data_sram_en), 32'd0);
        chk("rst sram_we", 32'(io.data_sram_we), 32'd0);
        chk("rst sram_addr", io.data_sram_addr, 32'd0);
        chk("rst wr_bus hi", 32'(io.EXE_wr_bus[38:32]), 32'd0);
        $display("tx reset checked");
        reset = 1'b0;
        io.MEM_allow_in = 1'b1;
        tick();

        // add.w 5 + 7, dest 3
        issue(mk(12'h001, 32'd5, 32'd7, 3'b000, 1'b0, 1'b1, 1'b0, 5'd3, 32'h0));
        chk("add valid", 32'(io.EXE_to_MEM_valid), 32'd1);
        chk("add result", io.EXE_to_MEM_bus[102:71], 32'd12);
        chk("add flags/dest", 32'(io.EXE_to_MEM_bus[70:64]), 32'h23);
        chk("add pc", io.EXE_to_MEM_bus[63:32], PC_C);
        chk("add inst", io.EXE_to_MEM_bus[31:0], INST_C);
        chk("add wr hi", 32'(io.EXE_wr_bus[38:32]), 32'h43);
        chk("add wr result", io.EXE_wr_bus[31:0], 32'd12);
        chk("add allow_in", 32'(io.EXE_allow_in), 32'd1);
        chk("add sram_en", 32'(io.data_sram_en), 32'd0);
        $display("tx add.w 5+7 -> %0d", io.EXE_to_MEM_bus[102:71]);
        tick();
        chk("add drained", 32'(io.EXE_to_MEM_valid), 32'd0);

        // sub.w 5 - 7
        issue(mk(12'h002, 32'd5, 32'd7, 3'b000, 1'b0, 1'b1, 1'b0, 5'd4, 32'h0));
        chk("sub result", io.EXE_to_MEM_bus[102:71], 32'hFFFF_FFFE);
        $display("tx sub.w 5-7 -> %08h", io.EXE_to_MEM_bus[102:71]);
        tick();

        // ld.w 0x2000 + 4, dest 9
        issue(mk(12'h001, 32'h2000, 32'h4, 3'b000, 1'b1, 1'b1, 1'b0, 5'd9, 32'h0));
        chk("ld sram_en", 32'(io.data_sram_en), 32'd1);
        chk("ld sram_we", 32'(io.data_sram_we), 32'd0);
        chk("ld sram_addr", io.data_sram_addr, 32'h2004);
        chk("ld wr hi", 32'(io.EXE_wr_bus[38:32]), 32'h69);
        $display("tx ld.w addr %08h", io.data_sram_addr);
        tick();

        run_div("div.wu 100/7", 1'b0, 1'b0, 32'd100, 32'd7, 32'd14);
        run_div("mod.wu 100/7", 1'b0, 1'b1, 32'd100, 32'd7, 32'd2);
        run_div("div.wu ffffffff/2", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF);
        run_div("div.w -7/2", 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_div("mod.w -7/2", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_div("div.w 7/-2", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
        run_div("mod.w 7/-2", 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1);
        run_div("div.w min/-1", 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_div("mod.w min/-1", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        run_div("div.w x/0", 1'b1, 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF);
        run_div("div.w -5/0", 1'b1, 1'b0, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF);
        run_div("mod.w 9/0", 1'b1, 1'b1, 32'd9, 32'd0, 32'd9);

        // Divider finishes under MEM backpressure; a second div waits at decode
        io.MEM_allow_in = 1'b0;
        issue(mk(12'h000, 32'd100, 32'd7, 3'b100, 1'b0, 1'b1, 1'b0, 5'd5, 32'h0));
        wait_valid(cyc);
        chk("bp latency", 32'(cyc), 32'd33);
        io.ID_to_EXE_valid = 1'b1;
        io.ID_to_EXE_bus   = mk(12'h000, 32'd100, 32'd7, 3'b101, 1'b0, 1'b1, 1'b0, 5'd6, 32'h0);
        for (int i = 0; i < 5; i++) begin
            chk("bp valid held", 32'(io.EXE_to_MEM_valid), 32'd1);
            chk("bp allow_in", 32'(io.EXE_allow_in), 32'd0);
            chk("bp result", io.EXE_to_MEM_bus[102:71], 32'd14);
            tick();
        end
        chk("bp state DONE", 32'(dut.u_div.state_reg), 32'(DONE));
        io.MEM_allow_in = 1'b1;
        #1;
        chk("bp allow on release", 32'(io.EXE_allow_in), 32'd1);
        $display("tx div.wu 100/7 held 5 cycles -> %0d", io.EXE_to_MEM_bus[102:71]);
        tick();
        io.ID_to_EXE_valid = 1'b0;
        chk("b2b dest", 32'(io.EXE_wr_bus[36:32]), 32'd6);
        wait_valid(cyc);
        chk("b2b latency", 32'(cyc), 32'd33);
        chk("b2b result", io.EXE_to_MEM_bus[102:71], 32'd2);
        $display("tx mod.wu back-to-back -> %0d after %0d cycles", io.EXE_to_MEM_bus[102:71], cyc);
        tick();

        // st.w with two stalled cycles before MEM accepts
        io.MEM_allow_in = 1'b0;
        issue(mk(12'h001, 32'h1000, 32'h0, 3'b000, 1'b0, 1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF));
        chk("st c0 sram_en", 32'(io.data_sram_en), 32'd0);
        chk("st c0 valid", 32'(io.EXE_to_MEM_valid), 32'd1);
        tick();
        chk("st c1 sram_en", 32'(io.data_sram_en), 32'd0);
        tick();
        io.MEM_allow_in = 1'b1;
        #1;
        chk("st sram_en", 32'(io.data_sram_en), 32'd1);
        chk("st sram_we", 32'(io.data_sram_we), 32'hF);
        chk("st sram_addr", io.data_sram_addr, 32'h1000);
        chk("st sram_wdata", io.data_sram_wdata, 32'hDEAD_BEEF);
        $display("tx st.w addr %08h data %08h", io.data_sram_addr, io.data_sram_wdata);
        tick();
        chk("st after sram_en", 32'(io.data_sram_en), 32'd0);

        // Reset in cycle 10 of a division, then a fresh division
        issue(mk(12'h000, 32'd100, 32'd7, 3'b100, 1'b0, 1'b1, 1'b0, 5'd8, 32'h0));
        repeat (10) tick();
        reset = 1'b1;
        #1;
        chk("mid-rst valid", 32'(io.EXE_to_MEM_valid), 32'd0);
        chk("mid-rst allow_in", 32'(io.EXE_allow_in), 32'd1);
        chk("mid-rst state", 32'(dut.u_div.state_reg), 32'(IDLE));
        $display("tx reset during division");
        tick();
        reset = 1'b0;
        tick();
        run_div("post-rst div.w -7/2", 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the five-stage in-order pipeline: sits between the decode stage and the memory stage and is the only producer of `EXE_to_MEM_bus`. It computes the single-cycle ALU result through the existing `alu` instance. It also runs a multi-cycle iterative divider for div.w/div.wu/mod.w/mod.wu, issues the data-SRAM request for ld.w/st.w, and publishes a forwarding/load-use bus to decode. It follows the pipeline valid/allow_in handshake.

## Interface
- `DIV_CYCLES`, 32: divider iteration count, one quotient bit per cycle.
- `clk` in 1: pipeline clock.
- `reset` in 1: asynchronous, active-high reset.
- `ID_to_EXE_valid` in 1: decode holds a valid instruction.
- `ID_to_EXE_bus` in 183: {alu_op[11:0], src1[31:0], src2[31:0], div_op[2:0], res_from_mem, gr_we, mem_we, dest[4:0], rkd_value[31:0], pc[31:0], inst[31:0]}.
- `EXE_allow_in` out 1: EXE can accept an instruction this cycle.
- `EXE_to_MEM_valid` out 1: EXE output valid and ready_go.
- `MEM_allow_in` in 1: MEM accepts this cycle.
- `EXE_to_MEM_bus` out 103: {result[31:0], res_from_mem, gr_we, dest[4:0], pc[31:0], inst[31:0]}.
- `data_sram_en` out 1: SRAM request strobe.
- `data_sram_we` out 4: byte write enables.
- `data_sram_addr` out 32: byte address.
- `data_sram_wdata` out 32: store data.
- `EXE_wr_bus` out 39: {EXE_write, EXE_is_load, dest[4:0], result[31:0]}, used for forwarding and load-use stall.

## Operation
- `div_op` = {is_div, is_signed, want_rem}. is_div=0 selects the ALU result.
- Latch rule: `EXE_valid` <= `ID_to_EXE_valid` when `EXE_allow_in`. The bus register loads on `ID_to_EXE_valid & EXE_allow_in`.
- `EXE_allow_in` = ~EXE_valid | (EXE_to_MEM_valid & MEM_allow_in).
- `ready_go` = ~is_div | (div_state == DONE). `EXE_to_MEM_valid` = EXE_valid & ready_go.
- Divider FSM, in sub-module `div_iter`:
  - IDLE -> BUSY when EXE_valid & is_div. Operands are latched and made unsigned when is_signed, count=0.
  - BUSY runs one restoring shift-subtract per cycle. It goes BUSY -> DONE when count == DIV_CYCLES-1.
  - DONE holds the result until the handoff (EXE_to_MEM_valid & MEM_allow_in), then goes to IDLE. A new div arriving the same cycle starts the following cycle.
- Sign fix-up when is_signed:
  - quotient is negated if the operand signs differ;
  - remainder takes the sign of the dividend.
- Divide by zero: quotient = 0xFFFFFFFF, remainder = dividend. No trap.
- 0x80000000 / -1 (signed): quotient = 0x80000000, remainder = 0.
- Memory access (word only):
  - `data_sram_en` = EXE_valid & (res_from_mem | mem_we) & MEM_allow_in & ready_go. Exactly one request is issued, and it is aligned with MEM entry.
  - `data_sram_we` = mem_we ? 4'hF : 4'h0.
  - `data_sram_addr` = ALU result; `data_sram_wdata` = rkd_value.
- `EXE_write` = gr_we & EXE_valid; `EXE_is_load` = res_from_mem & EXE_valid. Dest and result are valid only when EXE_write is high. During BUSY, `EXE_is_load` is 0 and decode must stall on a dest match with `EXE_write` while ~ready_go.

## Timing
- Reset values (asynchronous):
  - EXE_valid = 0, div_state = IDLE, count = 0.
  - All outputs are 0, except `EXE_allow_in` = 1.
  - The bus register is don't-care but holds no X on the output muxes.
- Non-div latency is 1 cycle: entered at edge N, handed to MEM at edge N+1 if `MEM_allow_in`.
- Div latency: define cycle 0 as the first cycle resident in EXE.
  - IDLE->BUSY at the end of cycle 0.
  - BUSY covers cycles 1..32.
  - `ready_go` = 1 from cycle 33.
  - Earliest handoff is the edge ending cycle 33, i.e. 34 cycles of residency.
- MEM backpressure: outputs stay stable and DONE persists. `data_sram_en` is held low until `MEM_allow_in`.
- Reset during BUSY/DONE: FSM goes to IDLE and the instruction is discarded. The first post-reset division is unaffected.

## Structure
- Shared package `pipe_pkg` holds:
  - bus widths: 183, 103, 39;
  - field offsets;
  - the `div_op` bit encoding;
  - the `div_state_t` enum {IDLE, BUSY, DONE}.
- Sub-module `div_iter` contains the FSM, counter, remainder/quotient shift registers and sign fix-up. Its ports are start, ack, signed, operands, done, quotient, remainder.
- `exe_stage` contains the handshake, result mux, SRAM request and forwarding bus.

## Test plan
- add.w src1=5, src2=7, `MEM_allow_in`=1 -> `EXE_to_MEM_bus` result 12 one cycle after entry, `EXE_wr_bus`={1,0,dest,12}.
- div.wu 100/7 -> `EXE_to_MEM_valid` first high in cycle 33, result 14; mod.wu with the same operands -> result 2.
- div.w -7/2 -> 0xFFFFFFFD; mod.w -> 0xFFFFFFFF. div.w 0x80000000/0xFFFFFFFF -> 0x80000000.
- div.w x/0 -> 0xFFFFFFFF; mod.w 9/0 -> 9.
- Div completes while `MEM_allow_in`=0 for 5 cycles -> DONE held, `EXE_allow_in`=0, result stable. It hands off on the first allow, and a back-to-back div starts the next cycle.
- st.w addr 0x1000, data 0xDEADBEEF with `MEM_allow_in` low for 2 cycles -> single `data_sram_en` pulse with we=4'hF on the handoff cycle. Asserting `reset` in cycle 10 of a division -> valid=0, IDLE; the next div is correct.
